// File: rtl/z88_pkg.sv
// Shared constants for the Z88 slot-bus controller.
// Optional wait-state insertion is enabled by defining SLOT_WAIT_EN.
package z88_pkg;

  // Chip-enable lane assignment
  localparam int unsigned CE_ROM = 0;
  localparam int unsigned CE_RAM = 1;
  localparam int unsigned CE_SE1 = 2;

  // Default debounce window in clock cycles
  localparam int unsigned DEB_CYCLES_DEF = 16;

  // Access FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/z88_slot_bus_if.sv
// CPU/memory-side bus bundle of the slot-bus controller.
// The controller sits on the slave modport; decode, memories and CPU drive the master side.
interface z88_slot_bus_if #(
  parameter int unsigned NUM_CE = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WS_W   = 2
) ();

  logic [NUM_CE-1:0]        ce_n;
  logic                     roe_n;
  logic                     wrb_n;
  logic                     mreq_n;
  logic                     iorq_n;
  logic                     rd_n;
  logic [DATA_W-1:0]        z80_do;
  logic [NUM_CE*DATA_W-1:0] mem_do;
  logic [NUM_CE*WS_W-1:0]   ws_cfg;
  logic [DATA_W-1:0]        cdi;
  logic                     wait_n;
  logic                     bus_err;

  modport master (
    output ce_n, roe_n, wrb_n, mreq_n, iorq_n, rd_n, z80_do, mem_do, ws_cfg,
    input  cdi, wait_n, bus_err
  );

  modport slave (
    input  ce_n, roe_n, wrb_n, mreq_n, iorq_n, rd_n, z80_do, mem_do, ws_cfg,
    output cdi, wait_n, bus_err
  );

endinterface

// File: rtl/z88_debounce.sv
// Single-bit switch debouncer: the output follows the raw input only after
// the raw value has differed from it for DEB_CYCLES consecutive cycles.
// tog_c is a combinational strobe, high in the cycle whose edge flips deb_o.
module z88_debounce
  import z88_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic deb_o,
  output logic tog_c
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  // Count consecutive disagreeing cycles; flip on the last one
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    tog_c = 1'b0;
    if (raw_i != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        deb_d = ~deb_q;
        tog_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/z88_slot_bus.sv
// Z88 slot-bus controller: lane arbitration, wait-state insertion, registered
// CPU read data, card/flap debounce and NMI event flags.
// Define SLOT_WAIT_EN to enable per-lane wait states (otherwise wait_n stays high).
module z88_slot_bus
  import z88_pkg::*;
#(
  parameter int unsigned NUM_CE     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WS_W       = 2,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CARD_SLOTS = NUM_CE - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  z88_slot_bus_if.slave         bus,
  input  logic [CARD_SLOTS-1:0] card_det,
  input  logic                  flap,
  input  logic                  nmi_ack,
  output logic                  nmi_n,
  output logic [CARD_SLOTS-1:0] card_status,
  output logic [CARD_SLOTS:0]   evt
);

  localparam int unsigned SEL_W = (NUM_CE > 1) ? $clog2(NUM_CE) : 1;
  localparam int unsigned EVT_W = CARD_SLOTS + 1;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              wait_n_q, wait_n_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] cdi_q, cdi_d;
  logic [EVT_W-1:0]  evt_q, evt_d;
  logic              nmi_n_q, nmi_n_d;

  logic              access_c;
  logic              multi_c;
  logic [SEL_W-1:0]  sel_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [EVT_W-1:0]  raw_c, deb_c, tog_c, set_c;

`ifdef SLOT_WAIT_EN
  logic [WS_W-1:0]   cnt_q, cnt_d;
  logic [WS_W-1:0]   ws_c;
`else
  logic              unused_ws;
  assign unused_ws = ^bus.ws_cfg;
`endif

  // Access detect, lowest-lane priority select and latched-lane read mux
  always_comb begin
    access_c  = (bus.ce_n != '1) && (!bus.roe_n || !bus.wrb_n);
    multi_c   = ($countones(~bus.ce_n) > 1);
    sel_c     = '0;
    rd_data_c = '1;
    for (int i = NUM_CE - 1; i >= 0; i--) begin
      if (!bus.ce_n[i]) sel_c = SEL_W'(i);
    end
    for (int i = 0; i < NUM_CE; i++) begin
      if (sel_q == SEL_W'(i)) rd_data_c = bus.mem_do[i*DATA_W +: DATA_W];
    end
  end

`ifdef SLOT_WAIT_EN
  // Wait-state count of the lane about to be latched
  always_comb begin
    ws_c = '0;
    for (int i = 0; i < NUM_CE; i++) begin
      if (sel_c == SEL_W'(i)) ws_c = bus.ws_cfg[i*WS_W +: WS_W];
    end
  end
`endif

  // Access FSM next state, wait_n and bus error strobe
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    wait_n_d  = 1'b1;
    bus_err_d = 1'b0;
`ifdef SLOT_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access_c) begin
          sel_d     = sel_c;
          bus_err_d = multi_c;
`ifdef SLOT_WAIT_EN
          cnt_d = ws_c;
          if (ws_c == '0) begin
            state_d = ST_HOLD;
          end else begin
            state_d  = ST_WAIT;
            wait_n_d = 1'b0;
          end
`else
          state_d = ST_HOLD;
`endif
        end
      end
`ifdef SLOT_WAIT_EN
      ST_WAIT: begin
        if (!access_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WS_W'(1)) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d    = cnt_q - WS_W'(1);
          wait_n_d = 1'b0;
        end
      end
`endif
      ST_HOLD: begin
        if (!access_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CPU read data source priority: memory read, loopback, idle ones
  always_comb begin
    if (state_q == ST_HOLD && !bus.roe_n) begin
      cdi_d = rd_data_c;
    end else if ((!bus.mreq_n || !bus.iorq_n) && bus.rd_n) begin
      cdi_d = bus.z80_do;
    end else begin
      cdi_d = '1;
    end
  end

  // Card and flap debouncers (flap is the top bit)
  assign raw_c = {flap, card_det};

  for (genvar g = 0; g < EVT_W; g++) begin : g_deb
    z88_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw_i (raw_c[g]),
      .deb_o (deb_c[g]),
      .tog_c (tog_c[g])
    );
  end

  // Sticky events: any card change, flap opening only; new events beat the ack
  always_comb begin
    set_c             = tog_c;
    set_c[CARD_SLOTS] = tog_c[CARD_SLOTS] & ~deb_c[CARD_SLOTS];
    evt_d             = (evt_q & ~{EVT_W{nmi_ack}}) | set_c;
    nmi_n_d           = ~|evt_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      wait_n_q  <= 1'b1;
      bus_err_q <= 1'b0;
      cdi_q     <= '1;
      evt_q     <= '0;
      nmi_n_q   <= 1'b1;
`ifdef SLOT_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      wait_n_q  <= wait_n_d;
      bus_err_q <= bus_err_d;
      cdi_q     <= cdi_d;
      evt_q     <= evt_d;
      nmi_n_q   <= nmi_n_d;
`ifdef SLOT_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.cdi     = cdi_q;
  assign bus.wait_n  = wait_n_q;
  assign bus.bus_err = bus_err_q;
  assign card_status = deb_c[CARD_SLOTS-1:0];
  assign evt         = evt_q;
  assign nmi_n       = nmi_n_q;

endmodule

// File: tb/tb_z88_slot_bus.sv
// Directed testbench for z88_slot_bus; expectations follow the SLOT_WAIT_EN setting.
module tb_z88_slot_bus;

  localparam int unsigned NUM_CE     = 5;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned WS_W       = 2;
  localparam int unsigned CARD_SLOTS = 3;

`ifdef SLOT_WAIT_EN
  localparam int EXP_ROM_LOW  = 2;   // wait_n low cycles for lane0 (ws=2)
  localparam int EXP_ROM_IDX  = 3;   // tick index where lane0 data first appears
  localparam logic EXP_W_SE1  = 1'b0; // wait_n after access start on lane2 (ws=3)
`else
  localparam int EXP_ROM_LOW  = 0;
  localparam int EXP_ROM_IDX  = 1;
  localparam logic EXP_W_SE1  = 1'b1;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CARD_SLOTS-1:0] card_det;
  logic                  flap;
  logic                  nmi_ack;
  logic                  nmi_n;
  logic [CARD_SLOTS-1:0] card_status;
  logic [CARD_SLOTS:0]   evt;

  int tests = 0;
  int fails = 0;

  z88_slot_bus_if #(.NUM_CE(NUM_CE), .DATA_W(DATA_W), .WS_W(WS_W)) bus ();

  z88_slot_bus #(
    .NUM_CE(NUM_CE), .DATA_W(DATA_W), .WS_W(WS_W), .DEB_CYCLES(16), .CARD_SLOTS(CARD_SLOTS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .card_det    (card_det),
    .flap        (flap),
    .nmi_ack     (nmi_ack),
    .nmi_n       (nmi_n),
    .card_status (card_status),
    .evt         (evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic end_access();
    bus.ce_n   = '1;
    bus.roe_n  = 1'b1;
    bus.wrb_n  = 1'b1;
    bus.mreq_n = 1'b1;
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
  endtask

  task automatic start_read(input logic [NUM_CE-1:0] ce);
    bus.ce_n   = ce;
    bus.roe_n  = 1'b0;
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    int first;
    logic seen;

    end_access();
    bus.z80_do = 8'h00;
    bus.mem_do = {8'h44, 8'h33, 8'h11, 8'h3C, 8'hA5};
    bus.ws_cfg = {2'd0, 2'd0, 2'd3, 2'd0, 2'd2};
    card_det   = '0;
    flap       = 1'b0;
    nmi_ack    = 1'b0;
    reset      = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_cdi",     32'(bus.cdi), 32'hFF);
    check("rst_wait_n",  32'(bus.wait_n), 32'h1);
    check("rst_nmi_n",   32'(nmi_n), 32'h1);
    check("rst_card",    32'(card_status), 32'h0);
    check("rst_evt",     32'(evt), 32'h0);
    check("rst_bus_err", 32'(bus.bus_err), 32'h0);

    // ROM read, lane0 ws=2, data A5
    start_read(5'b11110);
    lowcnt = 0;
    first  = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.wait_n === 1'b0) lowcnt++;
      if (first < 0 && bus.cdi === 8'hA5) first = i;
    end
    check("rom_wait_cycles", 32'(lowcnt), 32'(EXP_ROM_LOW));
    check("rom_cdi_latency", 32'(first), 32'(EXP_ROM_IDX));
    check("rom_cdi_hold",    32'(bus.cdi), 32'hA5);
    check("rom_bus_err",     32'(bus.bus_err), 32'h0);
    end_access();
    tick();
    check("rom_end_cdi",     32'(bus.cdi), 32'hFF);
    check("rom_end_wait_n",  32'(bus.wait_n), 32'h1);

    // RAM read, lane1 ws=0, data 3C
    start_read(5'b11101);
    tick();
    check("ram_entry_wait_n", 32'(bus.wait_n), 32'h1);
    check("ram_entry_cdi",    32'(bus.cdi), 32'hFF);
    check("ram_bus_err",      32'(bus.bus_err), 32'h0);
    tick();
    check("ram_cdi",          32'(bus.cdi), 32'h3C);
    check("ram_wait_n",       32'(bus.wait_n), 32'h1);
    end_access();
    tick();
    check("idle_cdi",         32'(bus.cdi), 32'hFF);

    // CPU write loopback with no chip enable
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b1;
    bus.z80_do = 8'h5A;
    tick();
    check("loopback_cdi", 32'(bus.cdi), 32'h5A);
    end_access();
    tick();
    check("loopback_end_cdi", 32'(bus.cdi), 32'hFF);

    // ROM and RAM both enabled: error pulse, lane0 served
    start_read(5'b11100);
    tick();
    check("multi_bus_err_hi", 32'(bus.bus_err), 32'h1);
    tick();
    check("multi_bus_err_lo", 32'(bus.bus_err), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!seen) begin
        tick();
        if (bus.cdi === 8'hA5) seen = 1'b1;
      end
    end
    check("multi_cdi_lane0", 32'(seen), 32'h1);
    end_access();
    tick();

    // Card detect: 10-cycle glitch is rejected
    card_det = 3'b001;
    repeat (10) tick();
    card_det = 3'b000;
    tick();
    check("glitch_card", 32'(card_status), 32'h0);
    check("glitch_evt",  32'(evt), 32'h0);

    // Stable insertion: status after 16 cycles
    card_det = 3'b001;
    repeat (15) tick();
    check("deb_15_card",  32'(card_status), 32'h0);
    check("deb_15_nmi_n", 32'(nmi_n), 32'h1);
    tick();
    check("deb_16_card",  32'(card_status), 32'h1);
    check("deb_16_evt",   32'(evt), 32'h1);
    check("deb_16_nmi_n", 32'(nmi_n), 32'h0);
    repeat (4) tick();
    check("deb_20_card",  32'(card_status), 32'h1);

    // Flap opening coincident with ack: new event survives, old clears
    flap = 1'b1;
    repeat (15) tick();
    check("flap_pre_evt", 32'(evt), 32'h1);
    nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    check("ack_race_evt",   32'(evt), 32'h8);
    check("ack_race_nmi_n", 32'(nmi_n), 32'h0);
    nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    check("ack_clear_evt",   32'(evt), 32'h0);
    check("ack_clear_nmi_n", 32'(nmi_n), 32'h1);

    // Flap closing raises nothing
    flap = 1'b0;
    repeat (17) tick();
    check("flap_close_evt",   32'(evt), 32'h0);
    check("flap_close_nmi_n", 32'(nmi_n), 32'h1);

    // Card removal is an event too
    card_det = 3'b000;
    repeat (16) tick();
    check("remove_card", 32'(card_status), 32'h0);
    check("remove_evt",  32'(evt), 32'h1);
    nmi_ack = 1'b1;
    tick();
    nmi_ack = 1'b0;
    check("remove_ack_evt", 32'(evt), 32'h0);

    // Reset during WAIT on lane2 (ws=3) after one wait cycle
    start_read(5'b11011);
    tick();
    check("se1_start_wait_n", 32'(bus.wait_n), 32'(EXP_W_SE1));
    tick();
    check("se1_wait2_wait_n", 32'(bus.wait_n), 32'(EXP_W_SE1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_wait_n",  32'(bus.wait_n), 32'h1);
    check("mid_rst_cdi",     32'(bus.cdi), 32'hFF);
    check("mid_rst_bus_err", 32'(bus.bus_err), 32'h0);
    // Access still held: FSM restarts from IDLE
    tick();
    check("restart_wait_n", 32'(bus.wait_n), 32'(EXP_W_SE1));
    check("restart_cdi",    32'(bus.cdi), 32'hFF);
    end_access();
    tick();
    check("final_wait_n", 32'(bus.wait_n), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/z88_slot_bus.md
Name: z88_slot_bus

Overview:
Parametrised slot-bus controller that replaces the fixed combinational CPU data-in mux of the top level.
- Arbitrates NUM_CE chip-enable lanes: internal ROM, internal RAM and card slots SE1..SEn.
- Inserts programmable per-lane wait states towards the Z80.
- Registers read data onto the CPU bus.
- Debounces card-detect and flap inputs and raises an NMI request on insertion, removal or flap opening.
- Sits between the Blink memory decode, the slot memories and the tv80s data input.

Parameters:
NUM_CE, 5, number of chip-enable lanes (lane 0 ROM, 1 RAM, 2..NUM_CE-1 card slots)
DATA_W, 8, data bus width
WS_W, 2, wait-state count width per lane (0..2^WS_W-1 waits)
DEB_CYCLES, 16, consecutive stable cycles required for debounce
CARD_SLOTS, NUM_CE-2, number of card-detect inputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ce_n  in  NUM_CE  active-low chip enables from Blink decode
roe_n  in  1  memory output enable (read strobe)
wrb_n  in  1  memory write strobe
mreq_n  in  1  Z80 memory request
iorq_n  in  1  Z80 IO request
rd_n  in  1  Z80 read
z80_do  in  DATA_W  Z80 data out (write/loopback source)
mem_do  in  NUM_CE*DATA_W  packed read data, lane i at [i*DATA_W +: DATA_W]
ws_cfg  in  NUM_CE*WS_W  packed per-lane wait-state count
card_det  in  CARD_SLOTS  raw card-present switches, 1 = present
flap  in  1  raw flap switch, 1 = open
nmi_ack  in  1  one-cycle acknowledge; clears event flags
cdi  out  DATA_W  registered data to CPU
wait_n  out  1  Z80 wait, active low
nmi_n  out  1  NMI request, active low, level
card_status  out  CARD_SLOTS  debounced card presence
evt  out  CARD_SLOTS+1  sticky events: [CARD_SLOTS-1:0] card change, [CARD_SLOTS] flap open
bus_err  out  1  one-cycle pulse: more than one ce_n low at access start

Behaviour:
- Reset state: cdi = all ones, wait_n = 1, nmi_n = 1, card_status = 0, evt = 0, bus_err = 0, FSM IDLE, debounce counters 0.
- Access definition: an access is active when any ce_n is low and (roe_n = 0 or wrb_n = 0).
- Lane selection: the selected lane is the lowest-index low ce_n. Selection is latched at access start.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE -> access starts: load counter with ws_cfg[sel].
    - Counter 0: go to HOLD.
    - Otherwise: go to WAIT and drive wait_n = 0 from the next cycle.
  - WAIT: counter decrements each cycle. wait_n = 0 for exactly ws_cfg cycles. At counter = 1, go to HOLD with wait_n = 1.
  - HOLD: remain until the access ends, then return to IDLE.
  - Access end (or abort) in any state: return to IDLE, wait_n = 1 next cycle.
- cdi register update priority, applied every cycle:
  1. In HOLD with roe_n = 0: load mem_do lane sel.
  2. Else if (mreq_n = 0 or iorq_n = 0) and rd_n = 1: load z80_do.
  3. Else: load all ones.
  - Latency: one cycle from HOLD entry to valid cdi.
- bus_err: pulses for 1 cycle at access start when popcount(~ce_n) > 1. The access still proceeds on the lowest lane.
- Debounce:
  - Each card_det bit and flap has its own counter.
  - The counter clears whenever the raw value equals the debounced value.
  - The debounced value toggles when the counter reaches DEB_CYCLES-1 with the raw value still different.
  - Glitches shorter than DEB_CYCLES never change status.
- Events:
  - Any card_status toggle sets its evt bit.
  - Debounced flap 0 -> 1 sets evt[CARD_SLOTS]; flap closing sets nothing.
  - nmi_n = ~|evt.
  - nmi_ack clears all evt bits, except that an event arriving in the same cycle as nmi_ack wins and stays set.
- Reset mid-operation: everything returns to reset values on the next edge, including an aborted WAIT.

Optional Feature:
SLOT_WAIT_EN
- Defined: per-lane wait-state insertion as described above.
- Undefined: ws_cfg ignored, WAIT state absent (IDLE -> HOLD directly), wait_n tied 1. All other behaviour unchanged.

Decomposition:
- Package z88_pkg:
  - FSM state enum.
  - Lane index constants CE_ROM = 0, CE_RAM = 1, CE_SE1 = 2.
  - Default DEB_CYCLES.
- Sub-module z88_debounce (parameter DEB_CYCLES, 1-bit raw in, debounced out, toggle pulse out), instantiated CARD_SLOTS+1 times.

Test Plan:
- ws_cfg lane0 = 2, ROM read, mem_do lane0 = 0xA5 -> wait_n low exactly 2 cycles; cdi = 0xA5 one cycle after HOLD entry.
- ws_cfg lane1 = 0, RAM read 0x3C -> wait_n never low; cdi = 0x3C after 1 cycle; idle with no strobes -> cdi = 0xFF.
- ce_n = 5'b11100 (ROM and RAM low) -> bus_err 1-cycle pulse; cdi = lane0 data.
- card_det[0] glitch 10 cycles then stable high 20 cycles (DEB_CYCLES = 16) -> no change on glitch; card_status[0] = 1 after 16 stable cycles; evt[0] = 1; nmi_n = 0.
- nmi_ack in the same cycle as a debounced flap opening with evt[0] set -> evt[0] clears, evt[CARD_SLOTS] = 1, nmi_n stays 0.
- reset asserted during WAIT (ws = 3, after 1 wait cycle) -> next cycle wait_n = 1, cdi = 0xFF, FSM IDLE.
